seq_checker: RTL
================

# seq_checker

Receive-side checker for the free-running 8-bit counter stream used in our co-simulation benches. It samples a counter value on every qualified clock edge, locks onto the incrementing sequence, and flags every sample that breaks the +1 (mod 2^WIDTH) progression. It sits in the bench or on-chip between a counter source and the sequence-capture hooks, and turns "does the count look right" into registered lock, error and statistics outputs.

## Interface
- WIDTH, 8, data width of the checked sequence
- LOCK_COUNT, 4, consecutive in-sequence samples needed to declare lock (>= 2)
- MISS_LIMIT, 3, consecutive out-of-sequence samples while locked that drop lock (>= 1)
- ERR_WIDTH, 8, width of the saturating error counter

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data is a sample this cycle
- in_data  in  WIDTH  sampled counter value
- clr  in  1  synchronous clear of err_count only
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle strobe per out-of-sequence sample while locked
- err_count  out  ERR_WIDTH  saturating count of err_pulse events
- expected  out  WIDTH  next value the checker predicts

## Operation
- States: HUNT, VERIFY, LOCKED. Reset state HUNT.
- in_valid low: no state, counter or output change, except err_pulse returns to 0 and clr still acts.
- HUNT, valid sample d: expected <= d+1, run <= 1, go VERIFY.
- VERIFY, d == expected: expected <= d+1, run <= run+1; if run+1 == LOCK_COUNT go LOCKED, miss <= 0.
- VERIFY, d != expected: expected <= d+1, run <= 1, stay VERIFY. No err_pulse, no err_count change (not yet locked).
- LOCKED, d == expected: expected <= d+1, miss <= 0.
- LOCKED, d != expected: err_pulse <= 1, err_count <= err_count+1 (saturate at 2^ERR_WIDTH-1), expected <= d+1 (resync to received value), miss <= miss+1; if miss+1 == MISS_LIMIT go HUNT.
- Arithmetic: expected is (d+1) mod 2^WIDTH; wrap from all-ones to 0 is in-sequence, never an error.
- clr and error in same cycle: clear first, then increment; err_count becomes 1.
- clr while err_count saturated: err_count becomes 0.
- Reset mid-operation: all state and outputs forced to reset values immediately, independent of clk.

## Timing
- Reset values: locked 0, err_pulse 0, err_count 0, expected 0; internal run 0, miss 0.
- All outputs registered; latency one cycle: effect of sample at edge N visible after edge N.
- locked rises on the edge that accepts the LOCK_COUNT-th consecutive in-sequence sample (first sample in HUNT counts as 1).
- locked falls on the edge that accepts the MISS_LIMIT-th consecutive miss; that same edge also raises err_pulse.
- err_pulse high exactly one cycle per bad sample; back-to-back misses give back-to-back pulses.
- No backpressure: every valid sample is consumed in the cycle presented.

## Test plan
- Reset released, feed 0,1,2,...,9 with in_valid=1 every cycle -> locked rises after sample 3 is accepted, err_count stays 0, expected=10 after last sample.
- Locked stream 250..255,0,1,2 (wrap) -> no err_pulse, locked stays 1, expected=3.
- Locked at expected=20, feed 20,21,40,41,42 -> single err_pulse after sample 40, err_count=1, locked stays 1, expected=43.
- Locked, feed three unrelated values 7,90,200 -> three consecutive err_pulse, err_count=3, locked falls with third pulse; then 201,202,203,204 -> relock, no new errors.
- Locked, drive err_count to 255 with ERR_WIDTH=8 via repeated single misses separated by good samples -> further misses keep err_count=255; assert clr together with a miss -> err_count=1.
- Mid-stream with locked=1 and err_count=5, pull rst low between clock edges -> locked, err_pulse, err_count, expected go to 0 without a clock edge; release and feed 0,1,2,3 -> relock normally.

Source files
------------

// File: rtl/seq_checker.sv
// Receive-side checker for an incrementing counter stream: hunts for the
// +1 progression, declares lock, and flags/counts out-of-sequence samples.
module seq_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 3,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;
    localparam logic [RUN_W-1:0]     RUN_LOCK  = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]    MISS_DROP = MISS_W'(MISS_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [RUN_W-1:0]     run_q,       run_d;
    logic [MISS_W-1:0]    miss_q,      miss_d;
    logic [WIDTH-1:0]     expected_q,  expected_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 locked_q,    locked_d;

    logic [WIDTH-1:0]     data_inc_c;
    logic                 in_seq_c;
    logic [ERR_WIDTH-1:0] err_base_c;

    assign data_inc_c = in_data + WIDTH'(1);
    assign in_seq_c   = (in_data == expected_q);
    // clr takes effect before any increment in the same cycle
    assign err_base_c = clr ? '0 : err_count_q;

    // Next-state and output computation
    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        miss_d      = miss_q;
        expected_d  = expected_q;
        err_count_d = err_base_c;
        err_pulse_d = 1'b0;

        if (in_valid) begin
            expected_d = data_inc_c;
            unique case (state_q)
                HUNT: begin
                    run_d   = RUN_W'(1);
                    state_d = VERIFY;
                end
                VERIFY: begin
                    if (in_seq_c) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_d == RUN_LOCK) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (in_seq_c) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_base_c != ERR_MAX) begin
                            err_count_d = err_base_c + ERR_WIDTH'(1);
                        end
                        miss_d = miss_q + MISS_W'(1);
                        if (miss_d == MISS_DROP) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            run_q       <= '0;
            miss_q      <= '0;
            expected_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;

endmodule
